// File: rtl/usb_tx_scheduler.sv
// Transmit sequencer: arbitrates handshake and endpoint packet requests onto the
// SIE byte interface and frames each grant as PID [+ payload + CRC16].
module usb_tx_scheduler #(
    parameter int NEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hs_req,
    input  logic [3:0]         hs_pid,
    output logic               hs_ack,
    input  logic [NEP-1:0]     ep_req,
    input  logic [NEP-1:0]     ep_toggle,
    input  logic [NEP-1:0]     ep_empty,
    input  logic [8*NEP-1:0]   ep_data,
    input  logic [NEP-1:0]     ep_last,
    output logic [NEP-1:0]     ep_rd,
    output logic [NEP-1:0]     ep_done,
    output logic [NEP-1:0]     grant,
    output logic               busy,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [2:0]         state_dbg
);

    localparam int IW = (NEP > 1) ? $clog2(NEP) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HS     = 3'd1,
        PID    = 3'd2,
        DATA   = 3'd3,
        CRC_LO = 3'd4,
        CRC_HI = 3'd5,
        GAP    = 3'd6
    } state_t;

    state_t        state, state_d;
    logic [IW-1:0] last_grant, g_idx, rr_idx;
    logic          rr_found;
    int            rr_dist, rr_best;
    logic [3:0]    hs_pid_q;
    logic          toggle_q, empty_q;
    logic [15:0]   crc;
    logic [7:0]    data_byte;
    logic          xfer;

    // Handshake: a byte moves on every cycle with tx_valid && tx_ready. ep_rd is a
    // registered pulse one cycle after the transfer; the endpoint must present its
    // next byte during that ep_rd cycle so back-to-back transfers see fresh data.
    assign xfer      = tx_valid && tx_ready;
    assign tx_valid  = (state == HS) || (state == PID) || (state == DATA) ||
                       (state == CRC_LO) || (state == CRC_HI);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            r = (r[0] ^ d[b]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // Round robin: smallest circular distance from last_grant+1 wins.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_dist  = 0;
        rr_best  = NEP;
        for (int i = 0; i < NEP; i++) begin
            if (ep_req[i]) begin
                rr_dist = (i > int'(last_grant)) ? (i - int'(last_grant) - 1)
                                                 : (i - int'(last_grant) - 1 + NEP);
                if (rr_dist < rr_best) begin
                    rr_best  = rr_dist;
                    rr_idx   = IW'(i);
                    rr_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (hs_req) state_d = HS;
                     else if (rr_found) state_d = PID;
            HS:      if (xfer) state_d = GAP;
            PID:     if (xfer) state_d = empty_q ? CRC_LO : DATA;
            DATA:    if (xfer && ep_last[g_idx]) state_d = CRC_LO;
            CRC_LO:  if (xfer) state_d = CRC_HI;
            CRC_HI:  if (xfer) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IW'(NEP - 1);
            g_idx      <= '0;
            grant      <= '0;
            hs_pid_q   <= 4'h0;
            toggle_q   <= 1'b0;
            empty_q    <= 1'b0;
            crc        <= 16'hFFFF;
            hs_ack     <= 1'b0;
            ep_rd      <= '0;
            ep_done    <= '0;
        end else begin
            hs_ack  <= 1'b0;
            ep_rd   <= '0;
            ep_done <= '0;
            case (state)
                IDLE: begin
                    if (hs_req) begin
                        hs_pid_q <= hs_pid;
                    end else if (rr_found) begin
                        g_idx      <= rr_idx;
                        last_grant <= rr_idx;
                        grant      <= NEP'(1) << rr_idx;
                        toggle_q   <= ep_toggle[rr_idx];
                        empty_q    <= ep_empty[rr_idx];
                    end
                end
                HS:   if (xfer) hs_ack <= 1'b1;
                PID:  crc <= 16'hFFFF;
                DATA: if (xfer) begin
                    crc   <= crc16_byte(crc, data_byte);
                    ep_rd <= grant;
                end
                CRC_HI: if (xfer) begin
                    ep_done <= grant;
                    grant   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Only the DATA byte is combinational, taken straight from the granted endpoint.
    always_comb begin
        data_byte = ep_data[{g_idx, 3'b000} +: 8];
        tx_data   = 8'h00;
        case (state)
            HS:      tx_data = {~hs_pid_q, hs_pid_q};
            PID:     tx_data = toggle_q ? 8'h4B : 8'hC3;
            DATA:    tx_data = data_byte;
            CRC_LO:  tx_data = ~crc[7:0];
            CRC_HI:  tx_data = ~crc[15:8];
            default: tx_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Self-checking bench for usb_tx_scheduler: directed scenarios plus randomized
// traffic, scored against a packet-level arbitration and CRC16 model.
module tb_usb_tx_scheduler;

    localparam int NEP = 4;

    logic             clk;
    logic             reset;
    logic             hs_req;
    logic [3:0]       hs_pid;
    logic             hs_ack;
    logic [NEP-1:0]   ep_req, ep_toggle, ep_empty, ep_last;
    logic [8*NEP-1:0] ep_data;
    logic [NEP-1:0]   ep_rd, ep_done, grant;
    logic             busy;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic [2:0]       state_dbg;

    usb_tx_scheduler #(.NEP(NEP)) dut (
        .clk(clk), .reset(reset),
        .hs_req(hs_req), .hs_pid(hs_pid), .hs_ack(hs_ack),
        .ep_req(ep_req), .ep_toggle(ep_toggle), .ep_empty(ep_empty),
        .ep_data(ep_data), .ep_last(ep_last),
        .ep_rd(ep_rd), .ep_done(ep_done), .grant(grant),
        .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- endpoint sources ----------------
    logic [7:0] pay [NEP][32];
    int plen [NEP];
    int issued [NEP];
    int done_cnt [NEP];
    int ptr [NEP];
    int cur_idx [NEP];
    logic rnd_ready = 1'b0;

    always_comb begin
        for (int e = 0; e < NEP; e++) begin
            cur_idx[e]        = ptr[e] + int'(ep_rd[e]);
            ep_req[e]         = (issued[e] != done_cnt[e]);
            ep_data[8*e +: 8] = (cur_idx[e] < 32) ? pay[e][cur_idx[e]] : 8'h00;
            ep_last[e]        = (cur_idx[e] == plen[e] - 1);
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < NEP; e++) begin
            if (ep_done[e]) done_cnt[e] <= done_cnt[e] + 1;
            if (reset || ep_done[e]) ptr[e] <= 0;
            else if (ep_rd[e])       ptr[e] <= ptr[e] + 1;
        end
    end

    always @(posedge clk) tx_ready <= rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

    // ---------------- reference model ----------------
    function automatic logic [15:0] crc16_model(input logic [7:0] bytes[$]);
        logic       bits[$];
        logic [15:0] r;
        logic       fb;
        foreach (bytes[i]) for (int b = 0; b < 8; b++) bits.push_back(bytes[i][b]);
        r = 16'hFFFF;
        foreach (bits[k]) begin
            fb = r[0] ^ bits[k];
            r  = r >> 1;
            if (fb) r = r ^ 16'hA001;
        end
        return r;
    endfunction

    function automatic int rr_pick(input logic [NEP-1:0] req, input int last);
        for (int d = 0; d < NEP; d++) begin
            if (req[(last + 1 + d) % NEP]) return (last + 1 + d) % NEP;
        end
        return -1;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [7:0]     exp_q[$];
    logic [7:0]     pkt_bytes[$];
    logic [7:0]     plq[$];
    int             grant_log[$];
    int             cyc = 0, m_last = NEP - 1, last_end_cyc = 0, rise_delta = 0, pkt_n = 0, w;
    int             rd_cnt [NEP];
    int             hs_ack_cnt = 0;
    logic           prev_valid = 1'b0, hs_prev = 1'b0, cur_is_data = 1'b0, expect_low = 1'b0;
    logic [3:0]     hs_pid_prev = 4'h0;
    logic [NEP-1:0] req_prev = '0;
    logic [7:0]     first_byte = 8'h00, eb;
    logic [15:0]    mcrc;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_q.delete();
                prev_valid = 1'b0; expect_low = 1'b0; hs_prev = 1'b0; req_prev = '0;
                m_last = NEP - 1;
            end else begin
                if (expect_low) begin
                    check("eop_low", tx_valid, 1'b0);
                    expect_low = 1'b0;
                end
                if (tx_valid && !prev_valid) begin
                    check("pkt_overlap", exp_q.size(), 0);
                    rise_delta = cyc - last_end_cyc;
                    pkt_n = 0;
                    pkt_bytes.delete();
                    if (hs_prev) begin
                        cur_is_data = 1'b0;
                        exp_q.push_back({~hs_pid_prev, hs_pid_prev});
                        check("hs_grant", grant, 0);
                    end else begin
                        w = rr_pick(req_prev, m_last);
                        check("pkt_expected", w >= 0, 1);
                        if (w >= 0) begin
                            cur_is_data = 1'b1;
                            check("grant", grant, 32'(1) << w);
                            m_last = w;
                            grant_log.push_back(w);
                            exp_q.push_back(ep_toggle[w] ? 8'h4B : 8'hC3);
                            plq.delete();
                            if (!ep_empty[w]) for (int i = 0; i < plen[w]; i++) plq.push_back(pay[w][i]);
                            foreach (plq[i]) exp_q.push_back(plq[i]);
                            mcrc = crc16_model(plq);
                            exp_q.push_back(~mcrc[7:0]);
                            exp_q.push_back(~mcrc[15:8]);
                        end
                    end
                end
                if (tx_valid && tx_ready) begin
                    check("byte_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        eb = exp_q.pop_front();
                        check("tx_byte", tx_data, eb);
                        if (pkt_n == 0) first_byte = tx_data;
                        else pkt_bytes.push_back(tx_data);
                        pkt_n++;
                        if (exp_q.size() == 0) begin
                            expect_low   = 1'b1;
                            last_end_cyc = cyc;
                            if (cur_is_data) check("crc_residual", crc16_model(pkt_bytes), 16'hB001);
                        end
                    end
                end
                if (|ep_rd) check("ep_rd_granted", $onehot(ep_rd) && ((ep_rd & ~grant) == '0), 1);
                for (int e = 0; e < NEP; e++) rd_cnt[e] += int'(ep_rd[e]);
                hs_ack_cnt += int'(hs_ack);
                hs_prev     = hs_req;
                hs_pid_prev = hs_pid;
                req_prev    = ep_req;
                prev_valid  = tx_valid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_ep(input int e, input int len, input logic tog, input logic seq);
        plen[e]      = len;
        ep_empty[e]  = (len == 0);
        ep_toggle[e] = tog;
        for (int i = 0; i < 32; i++) pay[e][i] = seq ? 8'(i) : 8'($urandom_range(0, 255));
    endtask

    task automatic send_hs(input logic [3:0] pid);
        hs_pid = pid;
        hs_req = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            if (hs_ack) break;
        end
        check("hs_ack_seen", hs_ack, 1'b1);
        hs_req = 1'b0;
    endtask

    task automatic wait_all();
        int pend;
        pend = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            pend = int'(hs_req) + int'(busy);
            for (int e = 0; e < NEP; e++) pend += issued[e] - done_cnt[e];
            if (pend == 0) break;
        end
        check("drain_pending", pend, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    logic [3:0] pids [3] = '{4'h2, 4'hA, 4'hE};
    int rd0, dn0, ack0, seen;
    logic do_hs;
    logic [3:0] mask;

    initial begin
        reset = 1'b1; hs_req = 1'b0; hs_pid = 4'h0; ep_toggle = '0; ep_empty = '0;
        for (int e = 0; e < NEP; e++) load_ep(e, 0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_hs_ack", hs_ack, 0);
        check("rst_ep_rd", ep_rd, 0);
        check("rst_ep_done", ep_done, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ACK handshake
        ack0 = hs_ack_cnt;
        send_hs(4'h2);
        wait_all();
        check("ack_first_byte", first_byte, 8'hD2);
        check("ack_pulses", hs_ack_cnt - ack0, 1);

        // Zero-length DATA1 on ep1
        rd0 = rd_cnt[1]; dn0 = done_cnt[1];
        load_ep(1, 0, 1'b1, 1'b1);
        issued[1]++;
        wait_all();
        check("zlp_first_byte", first_byte, 8'h4B);
        check("zlp_ep_rd", rd_cnt[1] - rd0, 0);
        check("zlp_ep_done", done_cnt[1] - dn0, 1);

        // Four-byte DATA0 payload on ep0
        rd0 = rd_cnt[0];
        load_ep(0, 4, 1'b0, 1'b1);
        issued[0]++;
        wait_all();
        check("pay_first_byte", first_byte, 8'hC3);
        check("pay_ep_rd", rd_cnt[0] - rd0, 4);

        // Handshake beats a simultaneous endpoint request
        grant_log.delete();
        load_ep(2, 3, 1'b1, 1'b0);
        fork
            send_hs(4'hA);
            issued[2]++;
        join
        wait_all();
        check("prio_ep2_rise", rise_delta, 3);
        check("prio_log_size", grant_log.size(), 1);

        // Round robin between ep0 and ep2 with tx_ready held high
        grant_log.delete();
        load_ep(0, 0, 1'b0, 1'b1);
        load_ep(2, 0, 1'b0, 1'b1);
        issued[0] += 2;
        issued[2] += 2;
        wait_all();
        check("rr_count", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++) check("rr_order", grant_log[i], (i % 2) * 2);

        // Reset in the middle of a payload
        load_ep(0, 6, 1'b0, 1'b1);
        dn0 = done_cnt[0];
        issued[0]++;
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (ep_rd[0]) seen++;
            if (seen == 2) break;
        end
        check("rd_before_reset", seen, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ep_done", ep_done, 0);
        reset = 1'b0;
        wait_all();
        check("restart_pid", first_byte, 8'hC3);
        check("restart_done", done_cnt[0] - dn0, 1);

        // Randomized traffic with a stalling SIE
        rnd_ready = 1'b1;
        for (int it = 0; it < 30; it++) begin
            do_hs = ($urandom_range(0, 2) == 0);
            mask  = 4'($urandom_range(do_hs ? 0 : 1, 15));
            for (int e = 0; e < NEP; e++) begin
                if (mask[e]) load_ep(e, $urandom_range(0, 8), 1'($urandom_range(0, 1)), 1'b0);
            end
            fork
                begin
                    if (do_hs) send_hs(pids[$urandom_range(0, 2)]);
                end
                begin
                    for (int e = 0; e < NEP; e++) if (mask[e]) issued[e]++;
                end
            join
            wait_all();
        end
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_scheduler.md
# usb_tx_scheduler

Transmit-side sequencer for the USB device. It shares the SIE transmit byte interface (`tx_data`/`tx_valid`/`tx_ready`) between the protocol engine's handshake requests and `NEP` endpoint data sources. It then frames each grant into a complete packet: a PID byte, then for data packets the payload and CRC16. It sits between the USB controller and endpoint buffers on one side and the SIE on the other, in the 24 MHz `clk` domain.

## Interface
- `NEP`, default 4: number of data endpoints (1..16).
- `clk`  in  1  system clock, 24 MHz.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `hs_req`  in  1  handshake request; held until `hs_ack`.
- `hs_pid`  in  4  handshake PID: ACK 4'h2, NAK 4'hA, STALL 4'hE.
- `hs_ack`  out  1  one-cycle pulse when the handshake byte is accepted.
- `ep_req`  in  NEP  data packet request per endpoint; held until `ep_done`.
- `ep_toggle`  in  NEP  0=DATA0 (4'h3), 1=DATA1 (4'hB); sampled at grant.
- `ep_empty`  in  NEP  1=zero-length packet; sampled at grant.
- `ep_data`  in  8*NEP  current byte per endpoint, byte i at [8i+7:8i]; stable until `ep_rd`.
- `ep_last`  in  NEP  current `ep_data` byte is the last payload byte.
- `ep_rd`  out  NEP  one-hot pulse: granted endpoint's current byte consumed.
- `ep_done`  out  NEP  one-hot pulse: packet fully sent.
- `grant`  out  NEP  one-hot owner of the current data packet; 0 otherwise.
- `busy`  out  1  state != IDLE.
- `tx_data`  out  8  byte to SIE.
- `tx_valid`  out  1  rise=SYNC, high=bytes pending, fall=EOP.
- `tx_ready`  in  1  SIE has taken `tx_data`.

## Operation
- States: IDLE, HS, PID, DATA, CRC_LO, CRC_HI, GAP.
- Byte transfer happens on any cycle with `tx_valid && tx_ready`. `tx_data` holds until transfer; the next byte appears the following cycle.
- PID byte format is `{~pid, pid}`.
- IDLE:
  - `hs_req` takes priority over any `ep_req` and goes to HS.
  - Otherwise the lowest requesting endpoint at or above `(last_grant+1) mod NEP` wins (round robin; `last_grant` resets to NEP-1). The winner is latched into `grant`, with its toggle and empty flags, and the state goes to PID.
- HS: drive `{~hs_pid,hs_pid}`. On transfer, pulse `hs_ack` and go to GAP.
- PID: drive the DATA0/DATA1 PID. CRC register is set to 16'hFFFF. On transfer, go to CRC_LO if empty, else DATA.
- DATA: drive `ep_data[grant]`.
  - On transfer, pulse `ep_rd[grant]` and fold the byte into the CRC, LSB first (poly 16'hA001 reflected form of x^16+x^15+x^2+1).
  - Go to CRC_LO if `ep_last[grant]`; otherwise stay in DATA.
- CRC_LO / CRC_HI: drive `~crc[7:0]`, then `~crc[15:8]`. On the CRC_HI transfer, pulse `ep_done[grant]`, clear `grant`, and go to GAP.
- GAP: `tx_valid`=0 for exactly one cycle (the EOP edge), then go to IDLE.
- `tx_valid`=1 in HS, PID, DATA, CRC_LO, CRC_HI; 0 in IDLE and GAP.
- A request dropped after grant is ignored; the packet completes.
- Reset mid-packet: all state is discarded, with no `ep_done` or `hs_ack`. The requester re-issues the request.
- Payload length is unbounded; the block does not enforce max packet size.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=8'h00, `hs_ack`=0, `ep_rd`=0, `ep_done`=0, `grant`=0, `busy`=0, `last_grant`=NEP-1, state=IDLE.
- Outputs are registered except `tx_data` in DATA, which is a mux of `ep_data` by registered `grant`.
- Request sampled in IDLE → `tx_valid` high the next cycle (1-cycle latency).
- Back-to-back packets are separated by exactly 2 cycles of `tx_valid`=0 (GAP + IDLE).
- `ep_rd`, `ep_done`, `hs_ack` are asserted in the cycle after the transfer cycle.
- `hs_req` and `ep_req` asserting in the same cycle: the handshake is sent first; the endpoint is granted after GAP/IDLE.
- `tx_ready` asserted while `tx_valid`=0 is ignored.

## Test plan
- ACK: `hs_req`=1, `hs_pid`=4'h2 → single byte 8'hD2.
  - `hs_ack` one pulse.
  - `tx_valid` low the cycle after transfer, for exactly 1 cycle.
- ZLP: `ep_req[1]`=1, `ep_toggle[1]`=1, `ep_empty[1]`=1 → bytes 8'h4B, 8'h00, 8'h00.
  - `grant`=4'b0010.
  - One `ep_done[1]` pulse, no `ep_rd`.
- Payload: ep0 DATA0, bytes 00,01,02,03 (`ep_last` on 03) → C3, 00, 01, 02, 03, then two CRC bytes.
  - CRC bytes match the bench CRC16 model.
  - CRC16 over payload+CRC yields residual 16'hB001 (reflected 0x800D).
  - 4 `ep_rd[0]` pulses.
- Priority: `hs_req` (NAK) and `ep_req[2]` rise together → 8'h5A first; ep2 packet `tx_valid` rises 3 cycles after the NAK transfer.
- Round robin: `ep_req`=4'b0101 held with ZLPs; `tx_ready` tied high → grants 0,2,0,2; each `ep_done` lowers that request for one packet.
- Reset mid-DATA after 2 payload bytes → next cycle `tx_valid`=0, `grant`=0, `busy`=0, no `ep_done`. The re-requested packet restarts with PID C3.
